// File: rtl/calc_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer_if
//
// Request/response bundle between a requester and the calculator operation
// sequencer.
//
// Signals:
//   start   requester -> sequencer  request strobe, only honoured while idle
//   op      requester -> sequencer  00 ADD, 01 SUB, 10 MUL, 11 DIV
//   a, b    requester -> sequencer  operands, latched on an accepted start
//   busy    sequencer -> requester  high whenever an operation is in flight
//   done    sequencer -> requester  one-cycle completion pulse
//   result  sequencer -> requester  sum / difference / product low byte / quotient
//   rem     sequencer -> requester  DIV remainder, 0 for other operations
//   ovf     sequencer -> requester  ADD carry, SUB borrow, MUL product overflow
//   err     sequencer -> requester  divide by zero
//
// Modports:
//   master  the requester side
//   slave   the sequencer side
// -----------------------------------------------------------------------------
interface calc_op_sequencer_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rem;
    logic             ovf;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, rem, ovf, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, rem, ovf, err
    );

endinterface : calc_op_sequencer_if

// File: rtl/calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer
//
// Multi-cycle controller for the calculator's shared add/subtract datapath.
// ADD and SUB take a single pass through the external ALU, MUL is done by
// repeated addition of the multiplicand and DIV by repeated subtraction of the
// divisor. Every datapath access goes through the one shared ALU port.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, wins over a same-cycle start
//   bus       calc_op_sequencer_if.slave: start/op/a/b in,
//             busy/done/result/rem/ovf/err out (all registered)
//   alu_a     shared ALU operand A      (combinational from state/registers)
//   alu_b     shared ALU operand B      (combinational from state/registers)
//   alu_sub   0 = add, 1 = subtract a-b (combinational from state/registers)
//   alu_res   ALU result, combinational from alu_a/alu_b/alu_sub
//   alu_cout  ALU carry-out, meaningful for add only
//
// Latency from the accepting edge to the edge that raises done:
//   ADD/SUB 1 edge, MUL b+1 edges, DIV quotient+1 edges (divide by zero 1).
// -----------------------------------------------------------------------------
module calc_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_op_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic                 alu_sub,
    input  logic [WIDTH-1:0]     alu_res,
    input  logic                 alu_cout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    state_e state_q;
    state_e state_d;

    // Operands latched on an accepted start; a later start cannot touch them
    // because they are only written in ST_IDLE.
    logic             sub_l;     // op[0]: selects SUB over ADD in ST_EXEC
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;

    // Iteration registers for MUL (acc, cnt) and DIV (rem_w, quo).
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo;

    // Registered outputs.
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;
    logic             ovf_q;
    logic             err_q;

    // Iteration decisions, shared by the next-state logic, the ALU decode and
    // the datapath update so all three always agree on what this cycle does.
    logic mul_step;
    logic div_zero;
    logic div_step;

    assign mul_step = (cnt != '0);
    assign div_zero = (b_l == '0);
    assign div_step = !div_zero && (rem_w >= b_l);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: the reset is synchronous, so it lives inside the clocked branch and
    // is not in the sensitivity list; it simply takes priority over every
    // other assignment made at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and ALU port decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sub = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    unique case (op_e'(bus.op))
                        OP_ADD, OP_SUB: state_d = ST_EXEC;
                        OP_MUL:         state_d = ST_MUL;
                        OP_DIV:         state_d = ST_DIV;
                        default:        state_d = ST_IDLE;
                    endcase
                end
            end

            ST_EXEC: begin
                alu_a   = a_l;
                alu_b   = b_l;
                alu_sub = sub_l;
                state_d = ST_DONE;
            end

            ST_MUL: begin
                if (mul_step) begin
                    alu_a = acc;
                    alu_b = a_l;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DIV: begin
                if (div_step) begin
                    alu_a   = rem_w;
                    alu_b   = b_l;
                    alu_sub = 1'b1;
                end else begin
                    // Covers both divide-by-zero and the normal exit.
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_l    <= 1'b0;
            a_l      <= '0;
            b_l      <= '0;
            acc      <= '0;
            cnt      <= '0;
            rem_w    <= '0;
            quo      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // busy/done are registered images of the state being entered, so
            // they line up exactly with the state they describe.
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        sub_l    <= bus.op[0];
                        a_l      <= bus.a;
                        b_l      <= bus.b;
                        acc      <= '0;
                        cnt      <= bus.b;
                        rem_w    <= bus.a;
                        quo      <= '0;
                        result_q <= '0;
                        rem_q    <= '0;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end

                ST_EXEC: begin
                    result_q <= alu_res;
                    // The ALU carry is only meaningful for add, so the borrow
                    // for SUB comes from a local magnitude compare.
                    ovf_q    <= sub_l ? (a_l < b_l) : alu_cout;
                end

                ST_MUL: begin
                    if (mul_step) begin
                        acc   <= alu_res;
                        // Any carry out of a partial sum means the full
                        // product does not fit in WIDTH bits.
                        ovf_q <= ovf_q | alu_cout;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        result_q <= acc;
                    end
                end

                ST_DIV: begin
                    if (div_zero) begin
                        err_q    <= 1'b1;
                        result_q <= '1;
                        rem_q    <= a_l;
                    end else if (div_step) begin
                        rem_w <= alu_res;
                        quo   <= quo + 1'b1;
                    end else begin
                        result_q <= quo;
                        rem_q    <= rem_w;
                    end
                end

                default: begin
                    // ST_DONE: results hold until the next accepted start.
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rem    = rem_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;

endmodule : calc_op_sequencer

// File: tb/tb_calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_op_sequencer
//
// Self-checking bench for calc_op_sequencer. A behavioural ALU closes the
// shared datapath loop; expected results are computed arithmetically from the
// operands and queued when each start is driven, then popped and compared when
// done rises.
// -----------------------------------------------------------------------------
module tb_calc_op_sequencer;

    localparam int WIDTH = 8;
    localparam int MAX_WAIT = 300;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    calc_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic [WIDTH:0]   alu_full;

    // Behavioural shared ALU: purely combinational add / subtract.
    assign alu_full = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b})
                              : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_res  = alu_full[WIDTH-1:0];
    assign alu_cout = alu_sub ? 1'b0 : alu_full[WIDTH];

    calc_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sub  (alu_sub),
        .alu_res  (alu_res),
        .alu_cout (alu_cout)
    );

    typedef struct {
        logic [7:0] result;
        logic [7:0] rem;
        logic       ovf;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    vec_t op_tbl [15] = '{
        '{2'd0, 8'hC8, 8'h64},   // ADD with carry
        '{2'd1, 8'h05, 8'h09},   // SUB with borrow
        '{2'd1, 8'h09, 8'h05},   // SUB no borrow
        '{2'd0, 8'h12, 8'h34},   // ADD no carry
        '{2'd0, 8'hFF, 8'h01},   // ADD wrap to zero
        '{2'd2, 8'h0C, 8'h05},   // MUL small
        '{2'd2, 8'h20, 8'h09},   // MUL overflow
        '{2'd2, 8'h37, 8'h00},   // MUL by zero
        '{2'd2, 8'h01, 8'hFF},   // MUL longest count
        '{2'd3, 8'h64, 8'h07},   // DIV with remainder
        '{2'd3, 8'h03, 8'h07},   // DIV dividend < divisor
        '{2'd3, 8'h5A, 8'h00},   // DIV by zero
        '{2'd3, 8'h07, 8'h07},   // DIV exact single step
        '{2'd3, 8'hFF, 8'h01},   // DIV longest quotient
        '{2'd1, 8'h00, 8'h00}    // SUB equal operands
    };

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b);
        exp_t e;
        int   s;
        e.rem = 8'h00;
        e.err = 1'b0;
        e.ovf = 1'b0;
        case (op)
            2'd0: begin
                s = int'(a) + int'(b);
                e.result = s[7:0];
                e.ovf = (s > 255);
                e.lat = 2;
            end
            2'd1: begin
                s = int'(a) - int'(b);
                e.result = s[7:0];
                e.ovf = (a < b);
                e.lat = 2;
            end
            2'd2: begin
                s = int'(a) * int'(b);
                e.result = s[7:0];
                e.ovf = (s > 255);
                e.lat = int'(b) + 2;
            end
            default: begin
                if (b == 8'h00) begin
                    e.result = 8'hFF;
                    e.rem = a;
                    e.err = 1'b1;
                    e.lat = 2;
                end else begin
                    s = int'(a) / int'(b);
                    e.result = s[7:0];
                    s = int'(a) % int'(b);
                    e.rem = s[7:0];
                    e.lat = int'(a) / int'(b) + 2;
                end
            end
        endcase
        return e;
    endfunction

    // Drives start for one edge from an idle cycle, then scrambles the
    // operand inputs so the DUT must rely on its latched copies.
    task automatic start_op(input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b, input bit track);
        if (track) sb.push_back(model(op, a, b));
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
    endtask

    // Counts edges (the accepting edge is edge 1) until done is sampled high.
    task automatic wait_done(input int first, output int edges, output bit seen);
        edges = first;
        seen  = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.result, bus.rem, bus.ovf, bus.err,
             alu_a, alu_b, alu_sub} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b done=%b result=%h rem=%h ovf=%b err=%b alu=%h/%h/%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.rem, bus.ovf, bus.err, alu_a, alu_b, alu_sub);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_datapath_ops();
        int   edges;
        bit   seen;
        exp_t e;
        foreach (op_tbl[i]) begin
            start_op(op_tbl[i].op, op_tbl[i].a, op_tbl[i].b, 1'b1);
            if (!op_tbl[i].op[1]) begin
                vectors++;
                if ({alu_a, alu_b, alu_sub} !== {op_tbl[i].a, op_tbl[i].b, op_tbl[i].op[0]}) begin
                    miscompares++;
                    $display("FAIL op%0d exec alu: got %h/%h/%b, want %h/%h/%b", i,
                             alu_a, alu_b, alu_sub, op_tbl[i].a, op_tbl[i].b, op_tbl[i].op[0]);
                end
            end
            wait_done(1, edges, seen);
            e = sb.pop_front();
            vectors++;
            if (!seen || edges != e.lat) begin
                miscompares++;
                $display("FAIL op%0d latency: got %0d edges (done seen=%0b), want %0d",
                         i, edges, seen, e.lat);
            end
            vectors++;
            if ({bus.result, bus.rem, bus.ovf, bus.err} !== {e.result, e.rem, e.ovf, e.err}) begin
                miscompares++;
                $display("FAIL op%0d outputs: got result=%h rem=%h ovf=%b err=%b, want result=%h rem=%h ovf=%b err=%b",
                         i, bus.result, bus.rem, bus.ovf, bus.err, e.result, e.rem, e.ovf, e.err);
            end
            vectors++;
            if ({bus.busy, alu_a, alu_b, alu_sub} !== {1'b1, 17'd0}) begin
                miscompares++;
                $display("FAIL op%0d done cycle: got busy=%b alu=%h/%h/%b, want busy=1 alu=0",
                         i, bus.busy, alu_a, alu_b, alu_sub);
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.busy, bus.done, bus.result, bus.rem, bus.ovf, bus.err} !==
                {2'b00, e.result, e.rem, e.ovf, e.err}) begin
                miscompares++;
                $display("FAIL op%0d idle hold: got busy=%b done=%b result=%h rem=%h, want busy=0 done=0 result=%h rem=%h",
                         i, bus.busy, bus.done, bus.result, bus.rem, e.result, e.rem);
            end
        end
    endtask

    task automatic test_busy_start();
        int   edges;
        bit   seen;
        int   extra_done;
        exp_t e;
        start_op(2'd2, 8'h0B, 8'h10, 1'b1);
        edges = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            edges++;
        end
        // Start with new operands while busy must be ignored.
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        repeat (2) begin
            @(posedge clk);
            #1;
            edges++;
        end
        bus.start = 1'b0;
        wait_done(edges, edges, seen);
        e = sb.pop_front();
        vectors++;
        if (!seen || edges != e.lat) begin
            miscompares++;
            $display("FAIL busy_start latency: got %0d edges (done seen=%0b), want %0d", edges, seen, e.lat);
        end
        vectors++;
        if ({bus.result, bus.ovf, bus.err} !== {e.result, e.ovf, e.err}) begin
            miscompares++;
            $display("FAIL busy_start outputs: got result=%h ovf=%b err=%b, want result=%h ovf=%b err=%b",
                     bus.result, bus.ovf, bus.err, e.result, e.ovf, e.err);
        end
        extra_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) extra_done++;
        end
        vectors++;
        if (extra_done != 0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start single done: got %0d extra done pulses busy=%b, want 0 busy=0",
                     extra_done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int   edges;
        bit   seen;
        exp_t e;
        start_op(2'd0, 8'h10, 8'h20, 1'b1);
        wait_done(1, edges, seen);
        e = sb.pop_front();
        vectors++;
        if (!seen || bus.result !== e.result) begin
            miscompares++;
            $display("FAIL b2b first: got result=%h (done seen=%0b), want %h", bus.result, seen, e.result);
        end
        // Start held from the DONE cycle: ignored there, accepted in IDLE.
        sb.push_back(model(2'd1, 8'h30, 8'h10));
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 8'h30;
        bus.b     = 8'h10;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b dead cycle: got busy=%b, want 0", bus.busy);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b accept: got busy=%b, want 1", bus.busy);
        end
        wait_done(1, edges, seen);
        e = sb.pop_front();
        vectors++;
        if (!seen || edges != e.lat || bus.result !== e.result || bus.ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL b2b second: got %0d edges result=%h ovf=%b (seen=%0b), want %0d edges result=%h ovf=%b",
                     edges, bus.result, bus.ovf, seen, e.lat, e.result, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int done_count;
        start_op(2'd3, 8'hFF, 8'h01, 1'b0);
        done_count = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) done_count++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({bus.busy, bus.done, bus.result, bus.rem, bus.ovf, bus.err,
             alu_a, alu_b, alu_sub} !== 37'd0) begin
            miscompares++;
            $display("FAIL abort: got busy=%b done=%b result=%h rem=%h ovf=%b err=%b alu=%h/%h/%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.rem, bus.ovf, bus.err, alu_a, alu_b, alu_sub);
        end
        repeat (MAX_WAIT) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_count++;
        end
        vectors++;
        if (done_count != 0) begin
            miscompares++;
            $display("FAIL abort no done: got %0d busy/done cycles, want 0", done_count);
        end
    endtask

    task automatic test_rst_start();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.a     = 8'h05;
        bus.b     = 8'h05;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        vectors++;
        if ({bus.busy, bus.done, alu_a, alu_b, alu_sub} !== 19'd0) begin
            miscompares++;
            $display("FAIL rst_start: got busy=%b done=%b alu=%h/%h/%b, want all 0",
                     bus.busy, bus.done, alu_a, alu_b, alu_sub);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_start idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_datapath_ops();
        test_busy_start();
        test_back_to_back();
        test_abort();
        test_rst_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_calc_op_sequencer
